// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store unit of the pipelined RV32 core.
// Takes one request at a time and drives a byte-write-enable RAM with a
// one-cycle registered read. A misaligned access that crosses a word
// boundary is split into two RAM accesses. Load data is returned aligned
// and sign- or zero-extended.
module load_store_unit #(
  parameter int ADDR_W           = 10,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_ena,
  output logic [3:0]        mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [31:0]       mem_dina,
  input  logic [31:0]       mem_douta
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_CAP,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  // latched request
  logic              r_store;
  logic [2:0]        r_funct3;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;

  // low word of a split load, and the registered response data
  logic [31:0]       r_lo;
  logic [31:0]       r_rdata;

  logic              w_accept;
  logic              w_req_err;

  logic [1:0]        w_off;
  logic [3:0]        w_size;
  logic              w_split;
  logic [ADDR_W-1:0] w_word0;
  logic [ADDR_W-1:0] w_word1;
  logic [7:0]        w_bytemask;
  logic [7:0]        w_lanes;
  logic [31:0]       w_dina0;
  logic [31:0]       w_dina1;

  logic [31:0]       w_lo;
  logic [31:0]       w_hi;
  logic [63:0]       w_pair;
  logic [31:0]       w_raw;
  logic [31:0]       w_ext;

  // upper address bits are ignored by design
  logic              w_unused;
  assign w_unused = &{1'b0, req_addr[31:ADDR_W+2], w_pair[63:32]};

  assign w_accept = req_valid && (r_state == S_IDLE) && !rst;

  // Classify the incoming request as legal or error at accept time
  always_comb begin
    w_req_err = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_req_err = 1'b0;
      3'b100, 3'b101:         w_req_err = req_store;
      default:                w_req_err = 1'b1;
    endcase
    if (!ALLOW_MISALIGNED) begin
      case (req_funct3[1:0])
        2'b01:   if (req_addr[0]) w_req_err = 1'b1;
        2'b10:   if (req_addr[1:0] != 2'b00) w_req_err = 1'b1;
        default: ;
      endcase
    end
  end

  // Decode of the latched request (RAM outputs derive only from these)
  always_comb begin
    w_off = r_addr[1:0];
    case (r_funct3[1:0])
      2'b00:   w_size = 4'd1;
      2'b01:   w_size = 4'd2;
      default: w_size = 4'd4;
    endcase
    w_split    = (({2'b00, w_off} + w_size) > 4'd4);
    w_word0    = r_addr[ADDR_W+1:2];
    w_word1    = w_word0 + ADDR_W'(1);
    w_bytemask = (8'd1 << w_size) - 8'd1;
    w_lanes    = w_bytemask << w_off;
    w_dina0    = r_wdata << {w_off, 3'b000};
    w_dina1    = r_wdata >> {(3'd4 - {1'b0, w_off}), 3'b000};
  end

  // Assemble, align and extend load data in the capture cycle
  always_comb begin
    w_lo   = w_split ? r_lo : mem_douta;
    w_hi   = w_split ? mem_douta : '0;
    w_pair = {w_hi, w_lo} >> {w_off, 3'b000};
    w_raw  = w_pair[31:0];
    case (r_funct3)
      3'b000:  w_ext = {{24{w_raw[7]}}, w_raw[7:0]};
      3'b100:  w_ext = {24'h000000, w_raw[7:0]};
      3'b001:  w_ext = {{16{w_raw[15]}}, w_raw[15:0]};
      3'b101:  w_ext = {16'h0000, w_raw[15:0]};
      default: w_ext = w_raw;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode; every output is forced low while rst is high
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_ena    = 1'b0;
    mem_wea    = '0;
    mem_addra  = '0;
    mem_dina   = '0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_req_err ? S_RESP : S_ACC0;
        end
      end
      S_ACC0: begin
        if (w_split) begin
          w_next = S_ACC1;
        end else if (r_store) begin
          w_next = S_RESP;
        end else begin
          w_next = S_CAP;
        end
      end
      S_ACC1: begin
        w_next = r_store ? S_RESP : S_CAP;
      end
      S_CAP: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    if (!rst) begin
      req_ready  = (r_state == S_IDLE);
      resp_valid = (r_state == S_RESP);
      resp_err   = (r_state == S_RESP) && r_err;
      resp_rdata = r_rdata;
      case (r_state)
        S_ACC0: begin
          mem_ena   = 1'b1;
          mem_addra = w_word0;
          if (r_store) begin
            mem_wea  = w_lanes[3:0];
            mem_dina = w_dina0;
          end
        end
        S_ACC1: begin
          mem_ena   = 1'b1;
          mem_addra = w_word1;
          if (r_store) begin
            mem_wea  = w_lanes[7:4];
            mem_dina = w_dina1;
          end
        end
        default: ;
      endcase
    end
  end

  // Request latch, split-load low word capture and response data register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_store  <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_lo     <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_store  <= req_store;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr[ADDR_W+1:0];
        r_wdata  <= req_wdata;
        r_err    <= w_req_err;
      end
      // in ACC1 the RAM presents the word read during ACC0
      if (r_state == S_ACC1) begin
        r_lo <= mem_douta;
      end
      // stores and errors respond with zero data; loads with the extended result
      if (w_next == S_RESP) begin
        r_rdata <= (r_state == S_CAP) ? w_ext : '0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: two instances (misaligned splitting enabled
// and disabled), each with its own behavioural byte-write RAM. Directed
// vectors from a table, plus hand sequences for hold and reset corner cases.
module tb_load_store_unit;

  logic clk;
  logic rst;
  logic ram_clr;

  logic        a_req_valid, a_req_ready, a_req_store;
  logic [2:0]  a_req_funct3;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_resp_valid, a_resp_err;
  logic [31:0] a_resp_rdata;
  logic        a_mem_ena;
  logic [3:0]  a_mem_wea;
  logic [9:0]  a_mem_addra;
  logic [31:0] a_mem_dina, a_douta;

  logic        b_req_valid, b_req_ready, b_req_store;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;
  logic        b_mem_ena;
  logic [3:0]  b_mem_wea;
  logic [9:0]  b_mem_addra;
  logic [31:0] b_mem_dina, b_douta;

  logic [31:0] ram_a [0:1023];
  logic [31:0] ram_b [0:1023];

  int n_tests;
  int n_fail;

  load_store_unit #(.ADDR_W(10), .ALLOW_MISALIGNED(1'b1)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_store(a_req_store),
    .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .mem_ena(a_mem_ena), .mem_wea(a_mem_wea), .mem_addra(a_mem_addra),
    .mem_dina(a_mem_dina), .mem_douta(a_douta)
  );

  load_store_unit #(.ADDR_W(10), .ALLOW_MISALIGNED(1'b0)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_store(b_req_store),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .mem_ena(b_mem_ena), .mem_wea(b_mem_wea), .mem_addra(b_mem_addra),
    .mem_dina(b_mem_dina), .mem_douta(b_douta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM A: synchronous read, byte writes; known contents at words 0 and 1023
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int k = 0; k < 1024; k++) ram_a[k] <= '0;
      ram_a[0]    <= 32'h123456C3;
      ram_a[1023] <= 32'h9A000000;
    end else if (a_mem_ena) begin
      for (int j = 0; j < 4; j++)
        if (a_mem_wea[j]) ram_a[a_mem_addra][8*j +: 8] <= a_mem_dina[8*j +: 8];
      a_douta <= ram_a[a_mem_addra];
    end
  end

  // RAM B: same behaviour, cleared to zero
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int k = 0; k < 1024; k++) ram_b[k] <= '0;
    end else if (b_mem_ena) begin
      for (int j = 0; j < 4; j++)
        if (b_mem_wea[j]) ram_b[b_mem_addra][8*j +: 8] <= b_mem_dina[8*j +: 8];
      b_douta <= ram_b[b_mem_addra];
    end
  end

  // view of whichever instance the current transaction targets
  logic        cur_sel;
  logic        m_ready, m_rvalid, m_err, m_ena;
  logic [31:0] m_rdata, m_dina;
  logic [3:0]  m_wea;
  logic [9:0]  m_addra;
  assign m_ready  = cur_sel ? b_req_ready  : a_req_ready;
  assign m_rvalid = cur_sel ? b_resp_valid : a_resp_valid;
  assign m_err    = cur_sel ? b_resp_err   : a_resp_err;
  assign m_rdata  = cur_sel ? b_resp_rdata : a_resp_rdata;
  assign m_ena    = cur_sel ? b_mem_ena    : a_mem_ena;
  assign m_wea    = cur_sel ? b_mem_wea    : a_mem_wea;
  assign m_addra  = cur_sel ? b_mem_addra  : a_mem_addra;
  assign m_dina   = cur_sel ? b_mem_dina   : a_mem_dina;

  logic [9:0]  lg_addr [0:8];
  logic [3:0]  lg_wea  [0:8];
  logic [31:0] lg_dina [0:8];

  typedef struct {
    bit          sel;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          nacc;
    logic [9:0]  a0;
    logic [3:0]  w0;
    logic [31:0] d0;
    logic [9:0]  a1;
    logic [3:0]  w1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit sel, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input int lat,
                              input logic [31:0] rd, input logic er, input int nacc,
                              input logic [9:0] a0, input logic [3:0] w0, input logic [31:0] d0,
                              input logic [9:0] a1, input logic [3:0] w1, input logic [31:0] d1);
    vec_t v;
    v.sel = sel; v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.lat = lat; v.rd = rd;
    v.er = er; v.nacc = nacc; v.a0 = a0; v.w0 = w0; v.d0 = d0; v.a1 = a1; v.w1 = w1; v.d1 = d1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one request from IDLE (called at posedge+1) and wait, bounded, for its response
  task automatic run_req(input bit sel, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input string nm,
                         output int lat, output int nacc, output logic [31:0] rd, output logic er);
    lat = 0; nacc = 0; rd = '0; er = 1'b0;
    for (int c = 0; c < 9; c++) begin
      lg_addr[c] = '0; lg_wea[c] = '0; lg_dina[c] = '0;
    end
    cur_sel = sel;
    if (sel) begin
      b_req_valid = 1'b1; b_req_store = st; b_req_funct3 = f3; b_req_addr = a; b_req_wdata = wd;
    end else begin
      a_req_valid = 1'b1; a_req_store = st; a_req_funct3 = f3; a_req_addr = a; a_req_wdata = wd;
    end
    @(negedge clk);
    chk({nm, " ready"}, {31'b0, m_ready}, 32'd1);
    chk({nm, " ena_in_accept"}, {31'b0, m_ena}, 32'd0);
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      lg_addr[c] = m_addra;
      lg_wea[c]  = m_wea;
      lg_dina[c] = m_dina;
      if (m_ena) nacc++;
      if (m_rvalid) begin
        lat = c; rd = m_rdata; er = m_err;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, nacc, quiet;
    logic [31:0] rd;
    logic er;
    string nm;

    n_tests = 0; n_fail = 0; cur_sel = 1'b0;
    rst = 1'b1; ram_clr = 1'b1;
    a_req_valid = 1'b0; a_req_store = 1'b0; a_req_funct3 = '0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_store = 1'b0; b_req_funct3 = '0; b_req_addr = '0; b_req_wdata = '0;

    //          sel st f3      addr          wdata         lat rdata         er n  a0      w0    d0            a1     w1    d1
    vecs.push_back(mk(0, 1, 3'b010, 32'h10,       32'hDEADBEEF, 2, 32'h0,        0, 1, 10'h4,  4'hF, 32'hDEADBEEF, 10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 3'b010, 32'h10,       32'h0,        3, 32'hDEADBEEF, 0, 1, 10'h4,  4'h0, 32'h0,        10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 1, 3'b000, 32'h13,       32'h80,       2, 32'h0,        0, 1, 10'h4,  4'h8, 32'h80000000, 10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 3'b000, 32'h13,       32'h0,        3, 32'hFFFFFF80, 0, 1, 10'h4,  4'h0, 32'h0,        10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 3'b100, 32'h13,       32'h0,        3, 32'h00000080, 0, 1, 10'h4,  4'h0, 32'h0,        10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 1, 3'b010, 32'h0E,       32'h11223344, 3, 32'h0,        0, 2, 10'h3,  4'hC, 32'h33440000, 10'h4, 4'h3, 32'h00001122));
    vecs.push_back(mk(0, 0, 3'b010, 32'h0E,       32'h0,        4, 32'h11223344, 0, 2, 10'h3,  4'h0, 32'h0,        10'h4, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 3'b001, 32'h12,       32'h0,        3, 32'hFFFF80AD, 0, 1, 10'h4,  4'h0, 32'h0,        10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 3'b101, 32'h12,       32'h0,        3, 32'h000080AD, 0, 1, 10'h4,  4'h0, 32'h0,        10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 3'b001, 32'hFFF,      32'h0,        4, 32'hFFFFC39A, 0, 2, 10'h3FF,4'h0, 32'h0,        10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 3'b101, 32'hFFF,      32'h0,        4, 32'h0000C39A, 0, 2, 10'h3FF,4'h0, 32'h0,        10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 3'b000, 32'h11,       32'h0,        3, 32'h00000011, 0, 1, 10'h4,  4'h0, 32'h0,        10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 3'b011, 32'h10,       32'h0,        1, 32'h0,        1, 0, 10'h0,  4'h0, 32'h0,        10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 1, 3'b100, 32'h10,       32'hFF,       1, 32'h0,        1, 0, 10'h0,  4'h0, 32'h0,        10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 3'b111, 32'h10,       32'h0,        1, 32'h0,        1, 0, 10'h0,  4'h0, 32'h0,        10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 3'b001, 32'h0F,       32'h0,        4, 32'h00002233, 0, 2, 10'h3,  4'h0, 32'h0,        10'h4, 4'h0, 32'h0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h13,       32'h0000BEEF, 3, 32'h0,        0, 2, 10'h4,  4'h8, 32'hEF000000, 10'h5, 4'h1, 32'h000000BE));
    vecs.push_back(mk(0, 0, 3'b010, 32'h13,       32'h0,        4, 32'h0000BEEF, 0, 2, 10'h4,  4'h0, 32'h0,        10'h5, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 3'b010, 32'h80000010, 32'h0,        3, 32'hEFAD1122, 0, 1, 10'h4,  4'h0, 32'h0,        10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 1, 3'b000, 32'h11,       32'hFFFFFF5A, 2, 32'h0,        0, 1, 10'h4,  4'h2, 32'hFFFF5A00, 10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 3'b100, 32'h11,       32'h0,        3, 32'h0000005A, 0, 1, 10'h4,  4'h0, 32'h0,        10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h02,       32'h0,        1, 32'h0,        1, 0, 10'h0,  4'h0, 32'h0,        10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h03,       32'h0,        1, 32'h0,        1, 0, 10'h0,  4'h0, 32'h0,        10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h04,       32'hCAFEF00D, 2, 32'h0,        0, 1, 10'h1,  4'hF, 32'hCAFEF00D, 10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h06,       32'h0,        3, 32'hFFFFCAFE, 0, 1, 10'h1,  4'h0, 32'h0,        10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h0E,       32'h12345678, 1, 32'h0,        1, 0, 10'h0,  4'h0, 32'h0,        10'h0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h07,       32'h0,        3, 32'hFFFFFFCA, 0, 1, 10'h1,  4'h0, 32'h0,        10'h0, 4'h0, 32'h0));

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready",  {31'b0, a_req_ready},  32'd0);
    chk("rst resp_valid", {31'b0, a_resp_valid}, 32'd0);
    chk("rst resp_err",   {31'b0, a_resp_err},   32'd0);
    chk("rst resp_rdata", a_resp_rdata,          32'd0);
    chk("rst mem_ena",    {31'b0, a_mem_ena},    32'd0);
    chk("rst mem_wea",    {28'b0, a_mem_wea},    32'd0);
    chk("rst mem_addra",  {22'b0, a_mem_addra},  32'd0);
    chk("rst mem_dina",   a_mem_dina,            32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ram_clr = 1'b0;

    foreach (vecs[i]) begin
      nm = $sformatf("v%0d", i);
      run_req(vecs[i].sel, vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd, nm, lat, nacc, rd, er);
      chk({nm, " latency"}, 32'(lat), 32'(vecs[i].lat));
      chk({nm, " rdata"}, rd, vecs[i].rd);
      chk({nm, " err"}, {31'b0, er}, {31'b0, vecs[i].er});
      chk({nm, " ram_accesses"}, 32'(nacc), 32'(vecs[i].nacc));
      if (vecs[i].nacc >= 1) begin
        chk({nm, " acc0 addr"}, {22'b0, lg_addr[1]}, {22'b0, vecs[i].a0});
        chk({nm, " acc0 wea"},  {28'b0, lg_wea[1]},  {28'b0, vecs[i].w0});
        chk({nm, " acc0 dina"}, lg_dina[1], vecs[i].d0);
      end
      if (vecs[i].nacc == 2) begin
        chk({nm, " acc1 addr"}, {22'b0, lg_addr[2]}, {22'b0, vecs[i].a1});
        chk({nm, " acc1 wea"},  {28'b0, lg_wea[2]},  {28'b0, vecs[i].w1});
        chk({nm, " acc1 dina"}, lg_dina[2], vecs[i].d1);
      end
    end

    // response data is held while idle
    run_req(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, "hold", lat, nacc, rd, er);
    chk("hold rdata", rd, 32'hEFAD5A22);
    @(negedge clk);
    chk("hold idle rdata", a_resp_rdata, 32'hEFAD5A22);
    chk("hold idle valid", {31'b0, a_resp_valid}, 32'd0);
    @(posedge clk);
    #1;

    // reset during ACC0 of a store: no write, no response
    cur_sel = 1'b0;
    a_req_valid = 1'b1; a_req_store = 1'b1; a_req_funct3 = 3'b010;
    a_req_addr = 32'h20; a_req_wdata = 32'h55AA55AA;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_acc0 wea",        {28'b0, a_mem_wea},    32'd0);
    chk("rst_acc0 ena",        {31'b0, a_mem_ena},    32'd0);
    chk("rst_acc0 resp_valid", {31'b0, a_resp_valid}, 32'd0);
    chk("rst_acc0 ready",      {31'b0, a_req_ready},  32'd0);
    chk("rst_acc0 rdata",      a_resp_rdata,          32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_acc0 ready after", {31'b0, a_req_ready}, 32'd1);
    quiet = 0;
    for (int c = 0; c < 3; c++) begin
      if (a_resp_valid) quiet++;
      @(negedge clk);
    end
    chk("rst_acc0 no resp", 32'(quiet), 32'd0);
    @(posedge clk);
    #1;
    run_req(1'b0, 1'b0, 3'b010, 32'h20, 32'h0, "rst_acc0 readback", lat, nacc, rd, er);
    chk("rst_acc0 word8", rd, 32'h0);

    // reset during ACC1 of a split store: first word written, second not
    a_req_valid = 1'b1; a_req_store = 1'b1; a_req_funct3 = 3'b010;
    a_req_addr = 32'h22; a_req_wdata = 32'h11112222;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_acc1 wea", {28'b0, a_mem_wea}, 32'd0);
    chk("rst_acc1 ena", {31'b0, a_mem_ena}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_req(1'b0, 1'b0, 3'b010, 32'h20, 32'h0, "rst_acc1 w8", lat, nacc, rd, er);
    chk("rst_acc1 word8", rd, 32'h22220000);
    run_req(1'b0, 1'b0, 3'b010, 32'h24, 32'h0, "rst_acc1 w9", lat, nacc, rd, er);
    chk("rst_acc1 word9", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
